// File: rtl/obi_data_arbiter.sv
// Two-requester OBI data-port arbiter in front of the mm_ram data port, with an ID FIFO routing responses.
// Optional macro OBI_DATA_ARB_RR_EN selects round-robin arbitration; the default build uses fixed priority (requester 0).
module obi_data_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  m_req_i,
    input  logic [63:0] m_addr_i,
    input  logic [1:0]  m_we_i,
    input  logic [7:0]  m_be_i,
    input  logic [63:0] m_wdata_i,
    output logic [1:0]  m_gnt_o,
    output logic [1:0]  m_rvalid_o,
    output logic [31:0] m_rdata_o,
    output logic        s_req_o,
    output logic [31:0] s_addr_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_wdata_o,
    input  logic        s_gnt_i,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i,
    output logic        err_o
);

    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                     r_state;
    logic                       r_locked_idx;
    logic [MAX_OUTSTANDING-1:0] r_ids;
    logic [PW-1:0]              r_wptr;
    logic [PW-1:0]              r_rptr;
    logic [CW-1:0]              r_count;
    logic                       r_err;

    logic w_idx;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_sreq;
    logic w_head;

    assign w_empty = (r_count == '0);
    assign w_pop   = s_rvalid_i & ~w_empty;
    // A response retiring this cycle frees a slot, so the request path reopens without waiting a cycle.
    assign w_full  = (r_count == CW'(MAX_OUTSTANDING)) & ~w_pop;
    assign w_sreq  = (|m_req_i) & ~w_full;
    assign w_push  = w_sreq & s_gnt_i;
    assign w_head  = r_ids[r_rptr];

`ifdef OBI_DATA_ARB_RR_EN
    logic r_prio;

    always_comb begin
        w_idx = 1'b0;
        if (r_state == LOCKED)
            w_idx = r_locked_idx;
        else if (&m_req_i)
            w_idx = r_prio;
        else
            w_idx = m_req_i[1] & ~m_req_i[0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_prio <= 1'b0;
        else if (w_push)
            r_prio <= ~w_idx;
    end
`else
    always_comb begin
        w_idx = 1'b0;
        if (r_state == LOCKED)
            w_idx = r_locked_idx;
        else
            w_idx = m_req_i[1] & ~m_req_i[0];
    end
`endif

    always_comb begin
        s_req_o   = w_sreq;
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_wdata_o = '0;
        if (w_sreq) begin
            s_addr_o  = w_idx ? m_addr_i[63:32]  : m_addr_i[31:0];
            s_we_o    = w_idx ? m_we_i[1]        : m_we_i[0];
            s_be_o    = w_idx ? m_be_i[7:4]      : m_be_i[3:0];
            s_wdata_o = w_idx ? m_wdata_i[63:32] : m_wdata_i[31:0];
        end
    end

    assign m_gnt_o    = {w_push & w_idx, w_push & ~w_idx};
    assign m_rvalid_o = {w_pop & w_head, w_pop & ~w_head};
    assign m_rdata_o  = w_pop ? s_rdata_i : '0;
    assign err_o      = r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_locked_idx <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sreq && !s_gnt_i) begin
                        r_state      <= LOCKED;
                        r_locked_idx <= w_idx;
                    end
                end
                LOCKED: begin
                    if (s_gnt_i)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ids   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_ids[r_wptr] <= w_idx;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (s_rvalid_i && w_empty)
                r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_obi_data_arbiter.sv
// Directed self-checking bench for obi_data_arbiter (MAX_OUTSTANDING = 2).
module tb_obi_data_arbiter;

    logic        clk_i;
    logic        rst_ni;
    logic [1:0]  m_req_i;
    logic [63:0] m_addr_i;
    logic [1:0]  m_we_i;
    logic [7:0]  m_be_i;
    logic [63:0] m_wdata_i;
    logic [1:0]  m_gnt_o;
    logic [1:0]  m_rvalid_o;
    logic [31:0] m_rdata_o;
    logic        s_req_o;
    logic [31:0] s_addr_o;
    logic        s_we_o;
    logic [3:0]  s_be_o;
    logic [31:0] s_wdata_o;
    logic        s_gnt_i;
    logic        s_rvalid_i;
    logic [31:0] s_rdata_i;
    logic        err_o;

    int n_checks = 0;
    int n_errors = 0;

    obi_data_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .m_req_i    (m_req_i),
        .m_addr_i   (m_addr_i),
        .m_we_i     (m_we_i),
        .m_be_i     (m_be_i),
        .m_wdata_i  (m_wdata_i),
        .m_gnt_o    (m_gnt_o),
        .m_rvalid_o (m_rvalid_o),
        .m_rdata_o  (m_rdata_o),
        .s_req_o    (s_req_o),
        .s_addr_o   (s_addr_o),
        .s_we_o     (s_we_o),
        .s_be_o     (s_be_o),
        .s_wdata_o  (s_wdata_o),
        .s_gnt_i    (s_gnt_i),
        .s_rvalid_i (s_rvalid_i),
        .s_rdata_i  (s_rdata_i),
        .err_o      (err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [1:0] exp_g [4];

    initial begin
        rst_ni = 1'b0; m_req_i = '0; m_addr_i = '0; m_we_i = '0; m_be_i = '0;
        m_wdata_i = '0; s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
        settle();
        chk("rst_s_req", s_req_o, 0);
        chk("rst_gnt", m_gnt_o, 0);
        chk("rst_rvalid", m_rvalid_o, 0);
        chk("rst_rdata", m_rdata_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_addr", s_addr_o, 0);
        step(); step();
        rst_ni = 1'b1;
        step();

        // single core read at 0x100
        m_req_i = 2'b01; m_addr_i = 64'h0000_0000_0000_0100; m_be_i = 8'h0F; s_gnt_i = 1'b1;
        settle();
        chk("rd_gnt", m_gnt_o, 2'b01);
        chk("rd_s_req", s_req_o, 1);
        chk("rd_addr", s_addr_o, 32'h100);
        chk("rd_be", s_be_o, 4'hF);
        chk("rd_we", s_we_o, 0);
        step();
        m_req_i = 2'b00; s_rvalid_i = 1'b1; s_rdata_i = 32'hDEAD_BEEF;
        settle();
        chk("rd_rvalid", m_rvalid_o, 2'b01);
        chk("rd_rdata", m_rdata_o, 32'hDEAD_BEEF);
        chk("rd_idle_addr", s_addr_o, 0);
        step();
        s_rvalid_i = 1'b0;
        settle();
        chk("rd_rdata_zero", m_rdata_o, 0);
        chk("rd_rvalid_zero", m_rvalid_o, 0);
        chk("rd_err", err_o, 0);

        // both requesters continuously, gnt and rvalid every cycle
`ifdef OBI_DATA_ARB_RR_EN
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
        exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
        m_req_i = 2'b11; m_addr_i = {32'h300, 32'h200}; m_be_i = 8'hFF; s_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_rvalid_i = (i != 0);
            s_rdata_i  = 32'h1000 + i;
            settle();
            chk($sformatf("both_gnt%0d", i), m_gnt_o, exp_g[i]);
            chk($sformatf("both_addr%0d", i), s_addr_o, exp_g[i] == 2'b01 ? 32'h200 : 32'h300);
            if (i != 0)
                chk($sformatf("both_rvalid%0d", i), m_rvalid_o, exp_g[i-1]);
            step();
        end
        m_req_i = 2'b00; s_rvalid_i = 1'b1;
        settle();
        chk("both_drain", m_rvalid_o, exp_g[3]);
        step();
        s_rvalid_i = 1'b0;

        // address phase held stable while the slave stalls
        m_req_i = 2'b01; m_addr_i = {32'h20, 32'h10}; s_gnt_i = 1'b0;
        settle();
        chk("stall_c1_addr", s_addr_o, 32'h10);
        chk("stall_c1_gnt", m_gnt_o, 2'b00);
        chk("stall_c1_req", s_req_o, 1);
        step();
        m_req_i = 2'b11;
        settle();
        chk("stall_c2_addr", s_addr_o, 32'h10);
        chk("stall_c2_gnt", m_gnt_o, 2'b00);
        step();
        settle();
        chk("stall_c3_addr", s_addr_o, 32'h10);
        step();
        s_gnt_i = 1'b1;
        settle();
        chk("stall_gnt", m_gnt_o, 2'b01);
        chk("stall_gnt_addr", s_addr_o, 32'h10);
        step();
        m_req_i = 2'b00; s_rvalid_i = 1'b1; s_rdata_i = 32'hABCD;
        settle();
        chk("stall_rvalid", m_rvalid_o, 2'b01);
        step();
        s_rvalid_i = 1'b0;

        // outstanding limit of 2
        m_req_i = 2'b01; m_addr_i = 64'h40; s_gnt_i = 1'b1;
        settle();
        chk("full_g1", m_gnt_o, 2'b01);
        step();
        settle();
        chk("full_g2", m_gnt_o, 2'b01);
        step();
        settle();
        chk("full_s_req", s_req_o, 0);
        chk("full_gnt", m_gnt_o, 2'b00);
        s_rvalid_i = 1'b1; s_rdata_i = 32'h55;
        settle();
        chk("full_reopen_req", s_req_o, 1);
        chk("full_reopen_gnt", m_gnt_o, 2'b01);
        chk("full_reopen_rvalid", m_rvalid_o, 2'b01);
        chk("full_reopen_rdata", m_rdata_o, 32'h55);
        step();
        m_req_i = 2'b00;
        settle();
        chk("full_pop2", m_rvalid_o, 2'b01);
        step();
        settle();
        chk("full_pop3", m_rvalid_o, 2'b01);
        step();
        s_rvalid_i = 1'b0;
        settle();
        chk("full_err", err_o, 0);

        // unexpected response
        s_rvalid_i = 1'b1; s_rdata_i = 32'h77;
        settle();
        chk("unexp_rvalid", m_rvalid_o, 2'b00);
        chk("unexp_rdata", m_rdata_o, 0);
        chk("unexp_err_same", err_o, 0);
        step();
        s_rvalid_i = 1'b0;
        settle();
        chk("unexp_err_set", err_o, 1);
        step();
        chk("unexp_err_sticky", err_o, 1);

        // debug-port write routed through
        m_req_i = 2'b10; m_we_i = 2'b10; m_addr_i = {32'h8000, 32'h0};
        m_be_i = 8'h30; m_wdata_i = {32'hCAFE_F00D, 32'h0};
        settle();
        chk("wr_gnt", m_gnt_o, 2'b10);
        chk("wr_addr", s_addr_o, 32'h8000);
        chk("wr_we", s_we_o, 1);
        chk("wr_be", s_be_o, 4'h3);
        chk("wr_wdata", s_wdata_o, 32'hCAFE_F00D);
        step();
        m_req_i = 2'b00; m_we_i = 2'b00; s_rvalid_i = 1'b1; s_rdata_i = 32'h0;
        settle();
        chk("wr_rvalid", m_rvalid_o, 2'b10);
        step();
        s_rvalid_i = 1'b0;

        // reset with one outstanding request, then a late response
        rst_ni = 1'b0;
        settle();
        chk("rst2_err_clear", err_o, 0);
        step();
        rst_ni = 1'b1;
        step();
        m_req_i = 2'b01; m_addr_i = 64'h44; m_be_i = 8'h0F; s_gnt_i = 1'b1;
        settle();
        chk("rst3_gnt", m_gnt_o, 2'b01);
        step();
        m_req_i = 2'b00;
        rst_ni = 1'b0;
        settle();
        chk("rst3_err", err_o, 0);
        step();
        rst_ni = 1'b1;
        step();
        s_rvalid_i = 1'b1; s_rdata_i = 32'h99;
        settle();
        chk("late_rvalid", m_rvalid_o, 2'b00);
        chk("late_rdata", m_rdata_o, 0);
        step();
        s_rvalid_i = 1'b0;
        settle();
        chk("late_err", err_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/obi_data_arbiter.md
OBI_DATA_ARBITER -- requirements
Module: obi_data_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, max responses pending at the slave (power of two, 2..8).
REQ-002 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port m_req_i  input  2  per-requester request; bit 0 = core data port, bit 1 = debug system bus.
REQ-005 SHALL have port m_addr_i  input  64  packed 2x32 addresses, [31:0] = requester 0.
REQ-006 SHALL have port m_we_i  input  2  per-requester write enable.
REQ-007 SHALL have port m_be_i  input  8  packed 2x4 byte enables.
REQ-008 SHALL have port m_wdata_i  input  64  packed 2x32 write data.
REQ-009 SHALL have port m_gnt_o  output  2  per-requester grant.
REQ-010 SHALL have port m_rvalid_o  output  2  per-requester response valid.
REQ-011 SHALL have port m_rdata_o  output  32  response data, shared by both requesters.
REQ-012 SHALL have port s_req_o / s_addr_o / s_we_o / s_be_o / s_wdata_o  output  1/32/1/4/32  request to the mm_ram data port.
REQ-013 SHALL have port s_gnt_i / s_rvalid_i / s_rdata_i  input  1/1/32  grant and response from the mm_ram data port.
REQ-014 SHALL have port err_o  output  1  sticky flag, set on an unexpected response.

Function
REQ-015 SHALL drive s_req_o = |m_req_i AND NOT full, combinationally.
REQ-016 SHALL route the winner's addr/we/be/wdata to the s_* outputs; outputs are 0 when s_req_o = 0.
REQ-017 SHALL drive m_gnt_o[winner] = s_gnt_i AND s_req_o, and the other grant bit to 0; zero-latency grant.
REQ-018 SHALL use FSM states IDLE and LOCKED.
- IDLE -> LOCKED when s_req_o=1 and s_gnt_i=0: the winner is registered.
- LOCKED -> IDLE on s_gnt_i=1.
- In LOCKED the winner is the registered index, regardless of the other request, so the address phase stays stable.
REQ-019 SHALL push the winner index into an ID FIFO of depth MAX_OUTSTANDING on s_req_o AND s_gnt_i.
REQ-020 SHALL pop the FIFO on s_rvalid_i when it is non-empty, and drive m_rvalid_o[head] = 1 with m_rdata_o = s_rdata_i in the same cycle (zero latency).
REQ-021 SHALL handle a simultaneous push and pop by leaving the count unchanged and advancing both pointers, with pointers wrapping modulo MAX_OUTSTANDING.
REQ-022 SHALL define full as count == MAX_OUTSTANDING; when full, s_req_o and m_gnt_o SHALL be 0.
REQ-023 SHALL, on s_rvalid_i with an empty FIFO, assert no m_rvalid_o, set err_o, and leave the count at 0.
REQ-024 SHALL drive m_rdata_o = 0 when no response is valid.

Reset
REQ-025 SHALL, on rst_ni low, immediately clear: FSM to IDLE, count, pointers, locked index, err_o and the priority pointer (to requester 0).
REQ-026 SHALL hold all outputs at 0 during reset, except pass-through combinational paths, which are gated by s_req_o.
REQ-027 SHALL discard outstanding IDs on reset mid-transaction; the later responses follow REQ-023.

Configuration
REQ-028 SHALL use macro OBI_DATA_ARB_RR_EN.
- Defined: round-robin; in IDLE, if both request, the requester not granted last wins; the priority pointer updates on each handshake.
- Undefined: fixed priority, requester 0 always wins in IDLE; no priority pointer register.

Verification
REQ-029 SHALL cover a single core read at 0x0000_0100, with s_gnt_i tied 1 and rvalid one cycle later: m_gnt_o=01 in the request cycle, m_rvalid_o=01 with m_rdata_o = s_rdata_i one cycle later.
REQ-030 SHALL cover both requesting continuously, with gnt=1 and rvalid every cycle:
- with RR_EN, grants alternate 01,10,01,10;
- without RR_EN, grants are 01 every cycle.
REQ-031 SHALL cover requester 0 requesting at 0x10 with s_gnt_i=0 for 3 cycles, and requester 1 asserting in cycle 2: s_addr_o stays 0x10 until grant and m_gnt_o=01 on the grant.
REQ-032 SHALL cover MAX_OUTSTANDING=2 with 2 grants and no rvalid: s_req_o=0 in cycle 3; one rvalid re-enables s_req_o in the same cycle.
REQ-033 SHALL cover s_rvalid_i pulsed with no outstanding request: m_rvalid_o=00 and err_o=1 from the next cycle until reset.
REQ-034 SHALL cover rst_ni asserted low with 1 outstanding request, then a late rvalid: no m_rvalid_o and err_o=1.
